adrv9001_enable_sequencer: RTL and testbench

Parametrised per-channel sequencer that drives the ADRV9001 TXn_EN / RXn_EN pins. It generalises fixed 2Tx/2Rx pin wiring to NUM_CH channels. Each path applies a programmable enable-setup delay, a turn-off hold and a re-arm guard. TDD mutual exclusion between the Tx and Rx paths of a channel is selectable at run time. Sits between the baseband control logic and the top-level adrv9001_txN_en / adrv9001_rxN_en outputs.

---
 rtl/adrv9001_enable_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_adrv9001_enable_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_enable_sequencer.sv
// Per-channel TXn_EN / RXn_EN sequencer for the ADRV9001.
// Each Tx and Rx path runs its own setup / hold / guard timing, with optional TDD exclusion per channel.

module adrv9001_enable_path #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             blocked,
    input  logic [CNT_W-1:0] on_delay,
    input  logic [CNT_W-1:0] off_delay,
    input  logic [CNT_W-1:0] guard_delay,
    output logic             en,
    output logic             active,
    output logic             idle
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ON    = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GUARD = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             active_q, active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            active_q <= active_d;
        end
    end

    // The counter holds a latched copy of the delay, so a state lasts delay+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !blocked) begin
                    state_d = ST_SETUP;
                    cnt_d   = on_delay;
                end
            end
            ST_SETUP: begin
                if (!req) begin
                    state_d = ST_HOLD;
                    cnt_d   = off_delay;
                end else if (cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (!req) begin
                    state_d = ST_HOLD;
                    cnt_d   = off_delay;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GUARD;
                    cnt_d   = guard_delay;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        en_d     = (state_d == ST_SETUP) || (state_d == ST_ON) || (state_d == ST_HOLD);
        active_d = (state_d == ST_ON);
    end

    assign en     = en_q;
    assign active = active_q;
    assign idle   = (state_q == ST_IDLE);

endmodule

module adrv9001_enable_sequencer #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int TX_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] tx_req,
    input  logic [NUM_CH-1:0] rx_req,
    input  logic [NUM_CH-1:0] tdd_mode,
    input  logic [CNT_W-1:0]  on_delay,
    input  logic [CNT_W-1:0]  off_delay,
    input  logic [CNT_W-1:0]  guard_delay,
    input  logic [NUM_CH-1:0] conflict_clr,
    output logic [NUM_CH-1:0] tx_en,
    output logic [NUM_CH-1:0] rx_en,
    output logic [NUM_CH-1:0] tx_active,
    output logic [NUM_CH-1:0] rx_active,
    output logic [NUM_CH-1:0] tdd_conflict
);

    localparam bit TX_WINS = (TX_PRIORITY != 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic tx_idle, rx_idle;
            logic tx_blocked, rx_blocked;
            logic conflict_q, conflict_d;

            // A path may only leave IDLE while its partner is IDLE; on a tie the priority path wins.
            always_comb begin
                tx_blocked = tdd_mode[gi] && (!rx_idle || (rx_req[gi] && !TX_WINS));
                rx_blocked = tdd_mode[gi] && (!tx_idle || (tx_req[gi] &&  TX_WINS));
                conflict_d = conflict_q;
                if (conflict_clr[gi]) begin
                    conflict_d = 1'b0;
                end
                if ((tx_req[gi] && tx_idle && tx_blocked) ||
                    (rx_req[gi] && rx_idle && rx_blocked)) begin
                    conflict_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    conflict_q <= 1'b0;
                end else begin
                    conflict_q <= conflict_d;
                end
            end

            assign tdd_conflict[gi] = conflict_q;

            adrv9001_enable_path #(
                .CNT_W (CNT_W)
            ) u_tx_path (
                .clk         (clk),
                .rst         (rst),
                .req         (tx_req[gi]),
                .blocked     (tx_blocked),
                .on_delay    (on_delay),
                .off_delay   (off_delay),
                .guard_delay (guard_delay),
                .en          (tx_en[gi]),
                .active      (tx_active[gi]),
                .idle        (tx_idle)
            );

            adrv9001_enable_path #(
                .CNT_W (CNT_W)
            ) u_rx_path (
                .clk         (clk),
                .rst         (rst),
                .req         (rx_req[gi]),
                .blocked     (rx_blocked),
                .on_delay    (on_delay),
                .off_delay   (off_delay),
                .guard_delay (guard_delay),
                .en          (rx_en[gi]),
                .active      (rx_active[gi]),
                .idle        (rx_idle)
            );
        end
    endgenerate

endmodule

// File: tb/tb_adrv9001_enable_sequencer.sv
// Scoreboard bench for adrv9001_enable_sequencer: expected output vectors are queued per cycle and compared at negedge.

module tb_adrv9001_enable_sequencer;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] tx_req, rx_req, tdd_mode, conflict_clr;
    logic [CNT_W-1:0]  on_delay, off_delay, guard_delay;
    logic [NUM_CH-1:0] tx_en, rx_en, tx_active, rx_active, tdd_conflict;

    typedef struct {
        logic [9:0] vec;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [9:0] got;
    int         tests  = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    adrv9001_enable_sequencer #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .TX_PRIORITY (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_req       (tx_req),
        .rx_req       (rx_req),
        .tdd_mode     (tdd_mode),
        .on_delay     (on_delay),
        .off_delay    (off_delay),
        .guard_delay  (guard_delay),
        .conflict_clr (conflict_clr),
        .tx_en        (tx_en),
        .rx_en        (rx_en),
        .tx_active    (tx_active),
        .rx_active    (rx_active),
        .tdd_conflict (tdd_conflict)
    );

    function automatic logic [9:0] pk(logic [1:0] te, logic [1:0] re, logic [1:0] ta,
                                      logic [1:0] ra, logic [1:0] cf);
        return {te, re, ta, ra, cf};
    endfunction

    function automatic logic [1:0] b(bit v);
        return {1'b0, v};
    endfunction

    function automatic logic [9:0] observed();
        return {tx_en, rx_en, tx_active, rx_active, tdd_conflict};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_req = '0; rx_req = '0; tdd_mode = '0; conflict_clr = '0;
        on_delay = '0; off_delay = '0; guard_delay = '0;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{vec: 10'd0, cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL reset cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_tx();
        on_delay = 16'd3; off_delay = 16'd2; guard_delay = 16'd1;
        for (int k = 0; k < 18; k++) begin
            tx_req = (k <= 9) ? 2'b01 : 2'b00;
            sb.push_back('{vec: pk(b(k >= 1 && k <= 13), 2'b00, b(k >= 5 && k <= 10), 2'b00, 2'b00), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL basic_tx cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
    endtask

    task automatic test_short_request();
        for (int k = 0; k < 10; k++) begin
            tx_req = (k <= 1) ? 2'b01 : 2'b00;
            sb.push_back('{vec: pk(b(k >= 1 && k <= 5), 2'b00, 2'b00, 2'b00, 2'b00), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL short_request cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
    endtask

    task automatic test_tdd_priority();
        tdd_mode = 2'b01;
        for (int k = 0; k < 24; k++) begin
            tx_req = (k <= 5)  ? 2'b01 : 2'b00;
            rx_req = (k <= 16) ? 2'b01 : 2'b00;
            sb.push_back('{vec: pk(b(k >= 1 && k <= 9), b(k >= 13 && k <= 20),
                                   b(k >= 5 && k <= 6), b(k == 17), b(k >= 1)), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL tdd_priority cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
    endtask

    task automatic test_independent_and_clear();
        for (int k = 0; k < 10; k++) begin
            tx_req       = (k <= 2) ? 2'b10 : 2'b00;
            rx_req       = (k <= 2) ? 2'b10 : 2'b00;
            conflict_clr = (k == 2) ? 2'b01 : 2'b00;
            sb.push_back('{vec: pk({(k >= 1 && k <= 6), 1'b0}, {(k >= 1 && k <= 6), 1'b0},
                                   2'b00, 2'b00, b(k <= 2)), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL independent_clear cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
        conflict_clr = '0;
    endtask

    task automatic test_zero_delays();
        int ph;
        on_delay = '0; off_delay = '0; guard_delay = '0;
        tdd_mode = '0;
        for (int k = 0; k < 20; k++) begin
            tx_req = ((k % 5) < 2) ? 2'b01 : 2'b00;
            ph = (k + 4) % 5;
            sb.push_back('{vec: pk(b(k >= 1 && ph <= 2), 2'b00, b(k >= 1 && ph == 1), 2'b00, 2'b00), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL zero_delays cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_on();
        bit en_exp, act_exp;
        on_delay = 16'd100; off_delay = 16'd2; guard_delay = 16'd1;
        for (int k = 0; k < 209; k++) begin
            tx_req = 2'b01;
            rst    = (k == 103);
            en_exp  = (k >= 1 && k <= 103) || (k >= 105);
            act_exp = (k >= 102 && k <= 103) || (k >= 206);
            sb.push_back('{vec: pk(b(en_exp), 2'b00, b(act_exp), 2'b00, 2'b00), cyc: k});
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e.vec) begin
                failed++;
                $display("FAIL reset_mid_on cycle %0d: got %b required %b", e.cyc, got, e.vec);
            end
            next_cycle();
        end
        rst    = 1'b0;
        tx_req = '0;
    endtask

    initial begin
        test_reset();
        test_basic_tx();
        test_short_request();
        test_tdd_priority();
        test_independent_and_clear();
        test_zero_delays();
        test_reset_mid_on();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
